gpi_axi_master: RTL and testbench
=================================

Name: gpi_axi_master

Overview:
Initiator-side bridge that turns a simple single-request peripheral interface into single-beat AXI3 master transactions (6-bit IDs, 2-bit lock, WID present).
It is the counterpart of the slave-side bridge in front of memory-mapped peripherals such as the CLINT.
The core, a debug module or a DMA engine drives it to reach AXI slaves.
One transaction is outstanding at a time; responses return as a one-cycle pulse.

Parameters:
AXI_ID, 6'd0, value driven on arid/awid/wid; returned rid/bid are ignored.
TIMEOUT_CYCLES, 1024, watchdog limit; used only when GPI_AXI_MASTER_TIMEOUT_EN is defined.

Ports:
clk  in  1  single clock; all logic rising-edge.
rst_n  in  1  reset, asynchronous, active-low.
req_valid  in  1  request present.
req_ready  out  1  request accepted when req_valid && req_ready.
req_write  in  1  1 = write, 0 = read.
req_addr  in  32  byte address; bits [1:0] forwarded unchanged.
req_wdata  in  32  write data.
req_wstrb  in  4  write byte strobes.
resp_valid  out  1  one-cycle completion pulse.
resp_rdata  out  32  read data; 0 for writes.
resp_err  out  1  1 = SLVERR/DECERR, or timeout.
axi_ar*  out  AXI3 read-address channel: arid 6, araddr 32, arlen 8, arsize 3, arburst 2, arlock 2, arcache 4, arprot 3, arvalid 1; arready in.
axi_r*  in  AXI3 read-data channel: rid 6, rdata 32, rresp 2, rlast 1, rvalid 1; rready out.
axi_aw*  out  AXI3 write-address channel, same widths as AR; awready in.
axi_w*  out  AXI3 write-data channel: wid 6, wdata 32, wstrb 4, wlast 1, wvalid 1; wready in.
axi_b*  in  AXI3 write-response channel: bid 6, bresp 2, bvalid 1; bready out.

Behaviour:
- Reset values: all valid/ready outputs 0 except req_ready=1; resp_rdata=0; resp_err=0; FSM in IDLE.
- Constant fields: arlen/awlen=0, arsize/awsize=3'b010, arburst/awburst=2'b01, lock/cache/prot=0, wlast=1.
- Address, data and strobes are latched on request acceptance and held stable while the matching valid is high.
- All outputs are registered.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
- IDLE: req_ready=1. On acceptance, go to RD_ADDR if reading, else WR_REQ. req_ready is 0 in every other state.
- RD_ADDR: arvalid=1 until arready is sampled high, then arvalid=0, rready=1, go to RD_DATA.
- RD_DATA: on rvalid, capture rdata; resp_err = rresp[1]; pulse resp_valid next cycle; rready=0; go to IDLE. rlast is not checked.
- WR_REQ: awvalid and wvalid are raised together; each drops independently on its own handshake, in either order or the same cycle. Once both have completed, bready=1 and go to WR_RESP.
- WR_RESP: on bvalid, resp_err = bresp[1], resp_rdata=0, pulse resp_valid, bready=0, go to IDLE.
- Latency with zero-wait slave, request accepted at cycle 0: arvalid at cycle 1, rready at cycle 2, resp_valid at cycle 3.
- Writes follow the same timing with B in place of R.
- A new request can be accepted in the cycle resp_valid is high.
- resp_valid is never back-pressured; the requester must sample it.
- Reset mid-transaction: all AXI valids and readys drop asynchronously and the FSM returns to IDLE. Permitted only under system-wide reset.

Optional Feature:
GPI_AXI_MASTER_TIMEOUT_EN
- Defined:
  - a cycle counter runs in every non-IDLE state and clears on each AXI handshake;
  - on reaching TIMEOUT_CYCLES, all valids/readys drop, resp_valid pulses with resp_err=1 and resp_rdata=32'h0, and the FSM goes to IDLE;
  - a late slave response after timeout is ignored because ready is 0.
- Not defined: no counter; the FSM waits indefinitely.

Decomposition:
- Package gpi_axi_pkg: FSM state enum, plus constants AXI_BURST_INCR, AXI_SIZE_4B, AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR.
- Optional sub-module gpi_axi_watchdog: counter with clear/expire, instantiated only under the macro.
- FSM and channel logic stay in one module.

Test Plan:
- Read 0x0200_0100, slave arready immediate, rdata=0x1234_5678, OKAY -> resp_valid at cycle 3, rdata 0x1234_5678, err=0.
- Write 0x0200_0000, wdata=1, wstrb=4'hF; awready arrives 3 cycles after wready -> each valid held until its own handshake, single bvalid, resp_err=0, resp_rdata=0.
- Read returning rresp=2'b10 after 5 wait cycles -> resp_valid with resp_err=1; req_ready stays 0 throughout.
- Back-to-back: read then write requested in the resp_valid cycle -> accepted, awvalid the next cycle, no idle bubble beyond one cycle.
- rst_n low while arvalid=1 -> arvalid=0 immediately (before the next clk edge); after release req_ready=1 and no resp_valid.
- Macro on, TIMEOUT_CYCLES=16, slave never asserts bvalid -> resp_valid/resp_err=1 exactly 16 cycles after the last handshake, bready=0 afterwards.

Source files
------------

// File: rtl/gpi_axi_pkg.sv
// Shared types and AXI3 encodings for the GPI-to-AXI3 initiator bridge.
package gpi_axi_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned ID_W   = 6;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B     = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_WR_REQ,
    ST_WR_RESP
  } state_e;

  // Request payload held stable for the lifetime of one transaction.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } gpi_req_t;

  function automatic logic resp_is_err(input logic [1:0] resp);
    logic err;
    unique case (resp)
      AXI_RESP_OKAY, AXI_RESP_EXOKAY:   err = 1'b0;
      AXI_RESP_SLVERR, AXI_RESP_DECERR: err = 1'b1;
      default:                          err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/gpi_axi_watchdog.sv
// Inactivity watchdog: counts cycles since the last handshake and flags expiry.
// Instantiated only when GPI_AXI_MASTER_TIMEOUT_EN is defined.
module gpi_axi_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic expire_o
);

  localparam int unsigned CNT_W     = $clog2(TIMEOUT_CYCLES) + 1;
  // Flag register plus the FSM register sit between the count and resp_valid.
  localparam int unsigned EXPIRE_AT = TIMEOUT_CYCLES - 3;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expire_q, expire_d;

  always_comb begin
    cnt_d    = cnt_q;
    expire_d = 1'b0;
    if (!en_i || clr_i) begin
      cnt_d = '0;
    end else begin
      cnt_d    = cnt_q + CNT_W'(1);
      expire_d = (cnt_q == CNT_W'(EXPIRE_AT));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      expire_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      expire_q <= expire_d;
    end
  end

  assign expire_o = expire_q;

endmodule

// File: rtl/gpi_axi_master.sv
// Single-outstanding GPI request to single-beat AXI3 master bridge.
// Optional watchdog timeout enabled by defining GPI_AXI_MASTER_TIMEOUT_EN.
module gpi_axi_master
  import gpi_axi_pkg::*;
#(
  parameter logic [ID_W-1:0] AXI_ID         = 6'd0,
  parameter int unsigned     TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [STRB_W-1:0] req_wstrb,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ID_W-1:0]   axi_arid,
  output logic [ADDR_W-1:0] axi_araddr,
  output logic [7:0]        axi_arlen,
  output logic [2:0]        axi_arsize,
  output logic [1:0]        axi_arburst,
  output logic [1:0]        axi_arlock,
  output logic [3:0]        axi_arcache,
  output logic [2:0]        axi_arprot,
  output logic              axi_arvalid,
  input  logic              axi_arready,
  input  logic [ID_W-1:0]   axi_rid,
  input  logic [DATA_W-1:0] axi_rdata,
  input  logic [1:0]        axi_rresp,
  input  logic              axi_rlast,
  input  logic              axi_rvalid,
  output logic              axi_rready,
  output logic [ID_W-1:0]   axi_awid,
  output logic [ADDR_W-1:0] axi_awaddr,
  output logic [7:0]        axi_awlen,
  output logic [2:0]        axi_awsize,
  output logic [1:0]        axi_awburst,
  output logic [1:0]        axi_awlock,
  output logic [3:0]        axi_awcache,
  output logic [2:0]        axi_awprot,
  output logic              axi_awvalid,
  input  logic              axi_awready,
  output logic [ID_W-1:0]   axi_wid,
  output logic [DATA_W-1:0] axi_wdata,
  output logic [STRB_W-1:0] axi_wstrb,
  output logic              axi_wlast,
  output logic              axi_wvalid,
  input  logic              axi_wready,
  input  logic [ID_W-1:0]   axi_bid,
  input  logic [1:0]        axi_bresp,
  input  logic              axi_bvalid,
  output logic              axi_bready
);

  state_e            state_q, state_d;
  gpi_req_t          req_q, req_d;
  logic              req_ready_q, req_ready_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              bready_q, bready_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;
  logic              wd_expire;

`ifdef GPI_AXI_MASTER_TIMEOUT_EN
  logic axi_hs;
  assign axi_hs = (arvalid_q & axi_arready) | (rready_q & axi_rvalid) |
                  (awvalid_q & axi_awready) | (wvalid_q & axi_wready) |
                  (bready_q & axi_bvalid);

  gpi_axi_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (state_q != ST_IDLE),
    .clr_i   (axi_hs),
    .expire_o(wd_expire)
  );
`else
  // No watchdog: a silent slave stalls the bridge indefinitely.
  assign wd_expire = 1'b0;
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // IDs and last-beat flags of returned beats carry no information here.
  logic unused_inputs;
  assign unused_inputs = ^{axi_rid, axi_bid, axi_rlast};

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    req_ready_d  = req_ready_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;

    if (wd_expire && (state_q != ST_IDLE)) begin
      state_d      = ST_IDLE;
      arvalid_d    = 1'b0;
      rready_d     = 1'b0;
      awvalid_d    = 1'b0;
      wvalid_d     = 1'b0;
      bready_d     = 1'b0;
      req_ready_d  = 1'b1;
      resp_valid_d = 1'b1;
      resp_err_d   = 1'b1;
      resp_rdata_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (req_valid && req_ready_q) begin
            req_d.addr  = req_addr;
            req_d.wdata = req_wdata;
            req_d.wstrb = req_wstrb;
            req_ready_d = 1'b0;
            if (req_write) begin
              awvalid_d = 1'b1;
              wvalid_d  = 1'b1;
              state_d   = ST_WR_REQ;
            end else begin
              arvalid_d = 1'b1;
              state_d   = ST_RD_ADDR;
            end
          end
        end
        ST_RD_ADDR: begin
          if (axi_arready) begin
            arvalid_d = 1'b0;
            rready_d  = 1'b1;
            state_d   = ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          if (axi_rvalid) begin
            rready_d     = 1'b0;
            resp_valid_d = 1'b1;
            resp_rdata_d = axi_rdata;
            resp_err_d   = resp_is_err(axi_rresp);
            req_ready_d  = 1'b1;
            state_d      = ST_IDLE;
          end
        end
        ST_WR_REQ: begin
          // AW and W retire independently; B is opened once both are gone.
          if (axi_awready) awvalid_d = 1'b0;
          if (axi_wready)  wvalid_d  = 1'b0;
          if (!awvalid_d && !wvalid_d) begin
            bready_d = 1'b1;
            state_d  = ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (axi_bvalid) begin
            bready_d     = 1'b0;
            resp_valid_d = 1'b1;
            resp_rdata_d = '0;
            resp_err_d   = resp_is_err(axi_bresp);
            req_ready_d  = 1'b1;
            state_d      = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      req_q        <= '0;
      req_ready_q  <= 1'b1;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      req_ready_q  <= req_ready_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_rdata  = resp_rdata_q;
  assign resp_err    = resp_err_q;

  assign axi_arid    = AXI_ID;
  assign axi_araddr  = req_q.addr;
  assign axi_arlen   = 8'd0;
  assign axi_arsize  = AXI_SIZE_4B;
  assign axi_arburst = AXI_BURST_INCR;
  assign axi_arlock  = 2'b00;
  assign axi_arcache = 4'h0;
  assign axi_arprot  = 3'h0;
  assign axi_arvalid = arvalid_q;
  assign axi_rready  = rready_q;

  assign axi_awid    = AXI_ID;
  assign axi_awaddr  = req_q.addr;
  assign axi_awlen   = 8'd0;
  assign axi_awsize  = AXI_SIZE_4B;
  assign axi_awburst = AXI_BURST_INCR;
  assign axi_awlock  = 2'b00;
  assign axi_awcache = 4'h0;
  assign axi_awprot  = 3'h0;
  assign axi_awvalid = awvalid_q;

  assign axi_wid     = AXI_ID;
  assign axi_wdata   = req_q.wdata;
  assign axi_wstrb   = req_q.wstrb;
  assign axi_wlast   = 1'b1;
  assign axi_wvalid  = wvalid_q;
  assign axi_bready  = bready_q;

endmodule

// File: tb/tb_gpi_axi_master.sv
// Directed and randomized bench for gpi_axi_master with a cycle-timing reference model.
module tb_gpi_axi_master;

  localparam int unsigned TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [5:0]  axi_arid, axi_rid, axi_awid, axi_wid, axi_bid;
  logic [31:0] axi_araddr, axi_awaddr, axi_rdata, axi_wdata;
  logic [7:0]  axi_arlen, axi_awlen;
  logic [2:0]  axi_arsize, axi_awsize, axi_arprot, axi_awprot;
  logic [1:0]  axi_arburst, axi_awburst, axi_arlock, axi_awlock, axi_rresp, axi_bresp;
  logic [3:0]  axi_arcache, axi_awcache, axi_wstrb;
  logic        axi_arvalid, axi_arready, axi_rlast, axi_rvalid, axi_rready;
  logic        axi_awvalid, axi_awready, axi_wlast, axi_wvalid, axi_wready;
  logic        axi_bvalid, axi_bready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gpi_axi_master #(
    .AXI_ID(6'd0),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
    .axi_arsize(axi_arsize), .axi_arburst(axi_arburst), .axi_arlock(axi_arlock),
    .axi_arcache(axi_arcache), .axi_arprot(axi_arprot), .axi_arvalid(axi_arvalid),
    .axi_arready(axi_arready),
    .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
    .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
    .axi_awsize(axi_awsize), .axi_awburst(axi_awburst), .axi_awlock(axi_awlock),
    .axi_awcache(axi_awcache), .axi_awprot(axi_awprot), .axi_awvalid(axi_awvalid),
    .axi_awready(axi_awready),
    .axi_wid(axi_wid), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
    .axi_wlast(axi_wlast), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid),
    .axi_bready(axi_bready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] ctl_now();
    return {req_ready, resp_valid, axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, axi_bready};
  endfunction

  // Idle cycles: bridge ready, nothing pending, no response.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("idle.ctl", 64'(ctl_now()), 64'(7'b1000000));
    end
  endtask

  // One transaction. Slave raises AR/AW ready after aw_w cycles of valid, W ready after w_w,
  // and the R/B beat after d_w cycles of ready. Cycle 0 is the acceptance cycle.
  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic [31:0] rdata, input logic [1:0] resp,
                         input int aw_w, input int w_w, input int d_w, input bit tmo,
                         input string tag);
    int m, done;
    logic [6:0] exp_ctl;
    logic [31:0] exp_rd;
    logic exp_err;
    m = (wr && (w_w > aw_w)) ? w_w : aw_w;
    done = tmo ? (1 + m + int'(TMO)) : (3 + m + d_w);
    exp_rd = (wr || tmo) ? 32'h0 : rdata;
    exp_err = tmo ? 1'b1 : resp[1];
    check({tag, ".req_ready"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_write = 1'($urandom); req_addr = $urandom;
    req_wdata = $urandom; req_wstrb = 4'($urandom);
    for (int c = 1; c <= done; c++) begin
      axi_arready = !wr && (c == 1 + aw_w);
      axi_rvalid  = !wr && (c == 2 + m + d_w);
      axi_rdata   = axi_rvalid ? rdata : $urandom;
      axi_rresp   = axi_rvalid ? resp : 2'($urandom);
      axi_rid     = 6'($urandom);
      axi_rlast   = 1'($urandom);
      axi_awready = wr && (c == 1 + aw_w);
      axi_wready  = wr && (c == 1 + w_w);
      axi_bvalid  = wr && !tmo && (c == 2 + m + d_w);
      axi_bresp   = axi_bvalid ? resp : 2'($urandom);
      axi_bid     = 6'($urandom);
      @(negedge clk);
      exp_ctl = {c == done, c == done,
                 !wr && (c <= 1 + aw_w), !wr && (c >= 2 + m) && (c < done),
                 wr && (c <= 1 + aw_w), wr && (c <= 1 + w_w),
                 wr && (c >= 2 + m) && (c < done)};
      check({tag, ".ctl"}, 64'(ctl_now()), 64'(exp_ctl));
      if (!wr && (c <= 1 + aw_w)) check({tag, ".araddr"}, 64'(axi_araddr), 64'(addr));
      if (wr && (c <= 1 + aw_w))  check({tag, ".awaddr"}, 64'(axi_awaddr), 64'(addr));
      if (wr && (c <= 1 + w_w))   check({tag, ".wbeat"}, 64'({axi_wdata, axi_wstrb}), 64'({wdata, strb}));
      if (c == done) check({tag, ".resp"}, 64'({resp_rdata, resp_err}), 64'({exp_rd, exp_err}));
      if (c != done) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    logic        wr;
    logic [31:0] a, d, r;
    logic [3:0]  s;
    logic [1:0]  rs;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    axi_arready = 1'b0; axi_rid = '0; axi_rdata = '0; axi_rresp = '0; axi_rlast = 1'b0;
    axi_rvalid = 1'b0; axi_awready = 1'b0; axi_wready = 1'b0; axi_bid = '0;
    axi_bresp = '0; axi_bvalid = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.ctl", 64'(ctl_now()), 64'(7'b1000000));
    check("reset.resp", 64'({resp_rdata, resp_err}), 64'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("const.ar", 64'({axi_arlen, axi_arsize, axi_arburst, axi_arlock, axi_arcache, axi_arprot}),
          64'({8'd0, 3'b010, 2'b01, 2'b00, 4'h0, 3'h0}));
    check("const.aw", 64'({axi_awlen, axi_awsize, axi_awburst, axi_awlock, axi_awcache, axi_awprot}),
          64'({8'd0, 3'b010, 2'b01, 2'b00, 4'h0, 3'h0}));
    check("const.misc", 64'({axi_wlast, axi_arid, axi_awid, axi_wid}), 64'({1'b1, 18'd0}));

    run_txn(1'b0, 32'h0200_0100, 32'h0, 4'h0, 32'h1234_5678, 2'b00, 0, 0, 0, 1'b0, "rd_basic");
    idle(1);
    run_txn(1'b1, 32'h0200_0000, 32'h1, 4'hF, 32'h0, 2'b00, 3, 0, 0, 1'b0, "wr_aw_late");
    idle(1);
    run_txn(1'b1, 32'h0200_0008, 32'hA5A5_0001, 4'h3, 32'h0, 2'b01, 0, 2, 1, 1'b0, "wr_w_late");
    idle(1);
    run_txn(1'b0, 32'h0200_0104, 32'h0, 4'h0, 32'hDEAD_BEEF, 2'b10, 0, 0, 5, 1'b0, "rd_slverr");
    run_txn(1'b0, 32'h1000_0003, 32'h0, 4'h0, 32'hCAFE_F00D, 2'b11, 2, 0, 0, 1'b0, "b2b_rd");
    run_txn(1'b1, 32'h1000_0010, 32'h5555_AAAA, 4'h9, 32'h0, 2'b11, 0, 0, 0, 1'b0, "b2b_wr");
    idle(2);

    for (int i = 0; i < 30; i++) begin
      wr = 1'($urandom); a = $urandom; d = $urandom; r = $urandom;
      s = 4'($urandom); rs = 2'($urandom);
      run_txn(wr, a, d, s, r, rs, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
              int'($urandom_range(0, 4)), 1'b0, "rand");
      idle(int'($urandom_range(0, 2)));
    end

`ifdef GPI_AXI_MASTER_TIMEOUT_EN
    run_txn(1'b1, 32'h0200_4000, 32'h7, 4'hF, 32'h0, 2'b00, 1, 2, 0, 1'b1, "timeout_wr");
    axi_bvalid = 1'b1;
    idle(1);
    axi_bvalid = 1'b0;
    idle(1);
`endif

    // Asynchronous reset while AR is pending.
    axi_arready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0300_0000;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("rst_mid.pre", 64'(axi_arvalid), 64'd1);
    #2 rst_n = 1'b0;
    #1 check("rst_mid.async", 64'(ctl_now()), 64'(7'b1000000));
    @(posedge clk);
    #2 rst_n = 1'b1;
    idle(3);
    run_txn(1'b0, 32'h0300_0004, 32'h0, 4'h0, 32'h0BAD_CAFE, 2'b00, 1, 0, 1, 1'b0, "post_rst_rd");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
